// File: rtl/zigzag_encryption.sv
// rtl/zigzag_encryption.sv - rail-fence encryption engine over a buffered, EOM-terminated byte stream
// Optional: define ZIGZAG_ENC_EOM_OUT_EN to append EOM_CHAR after the ciphertext.
module zigzag_encryption #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    KEY_WIDTH  = 8,
  parameter int                    MAX_LEN    = 50,
  parameter logic [DATA_WIDTH-1:0] EOM_CHAR   = 8'hFA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic [KEY_WIDTH-1:0]  key,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  localparam int AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LW  = $clog2(MAX_LEN + 1);
  localparam int IW0 = (KEY_WIDTH + 2 > LW + 2) ? KEY_WIDTH + 2 : LW + 2;
  localparam int IW  = (IW0 > 10) ? IW0 : 10;

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [IW-1:0] ONE_I     = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EMIT,
    S_EOM,
    S_DONE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [MAX_LEN];
  logic [LW-1:0]         len;
  logic [IW-1:0]         k;
  logic [IW-1:0]         p;
  logic [IW-1:0]         r;
  logic [IW-1:0]         i;
  logic                  tog;

  logic                  collecting;
  logic [LW-1:0]         cur_len;
  logic                  accept_char;
  logic                  accept_eom;
  logic                  wr_en;

  logic [IW-1:0]         len_x;
  logic [IW-1:0]         step;
  logic [IW-1:0]         ni;
  logic [IW-1:0]         nr;
  logic                  rail_end;
  logic                  last;
  logic [IW-1:0]         nxt_i;
  logic [AW-1:0]         rd_idx;

  // DONE behaves as a collecting cycle with the length already cleared.
  always_comb begin
    collecting  = (state == S_IDLE) || (state == S_DONE);
    cur_len     = (state == S_DONE) ? '0 : len;
    accept_char = collecting && valid_i && (data_i != EOM_CHAR);
    accept_eom  = collecting && valid_i && (data_i == EOM_CHAR);
    wr_en       = accept_char && (cur_len < MAX_LEN_L);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cur_len[AW-1:0]] <= data_i;
    end
  end

  // Next index of the rail walk, evaluated against the character currently on data_o.
  always_comb begin
    len_x = IW'(len);
    step  = ONE_I;
    if (k > ONE_I) begin
      if ((r == '0) || (r == k - ONE_I)) begin
        step = p;
      end else if (tog) begin
        step = r << 1;
      end else begin
        step = p - (r << 1);
      end
    end
    ni       = i + step;
    nr       = r + ONE_I;
    rail_end = (ni >= len_x);
    last     = rail_end && ((nr >= k) || (nr >= len_x));
    nxt_i    = rail_end ? nr : ni;
    rd_idx   = nxt_i[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      len     <= '0;
      busy    <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
      k       <= '0;
      p       <= '0;
      r       <= '0;
      i       <= '0;
      tog     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          busy    <= 1'b0;
          valid_o <= 1'b0;
          data_o  <= '0;
          len     <= wr_en ? cur_len + LW'(1) : cur_len;
          if (accept_eom) begin
            k     <= IW'(key);
            busy  <= 1'b1;
            state <= S_SETUP;
          end else begin
            state <= S_IDLE;
          end
        end

        S_SETUP: begin
          p   <= (k - ONE_I) << 1;
          r   <= '0;
          i   <= '0;
          tog <= 1'b0;
          if (len == '0) begin
`ifdef ZIGZAG_ENC_EOM_OUT_EN
            valid_o <= 1'b1;
            data_o  <= EOM_CHAR;
            state   <= S_EOM;
`else
            busy    <= 1'b0;
            state   <= S_DONE;
`endif
          end else begin
            valid_o <= 1'b1;
            data_o  <= mem[0];
            state   <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (last) begin
`ifdef ZIGZAG_ENC_EOM_OUT_EN
            data_o  <= EOM_CHAR;
            state   <= S_EOM;
`else
            busy    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            state   <= S_DONE;
`endif
          end else begin
            i      <= nxt_i;
            r      <= rail_end ? nr : r;
            tog    <= rail_end ? 1'b0 : ~tog;
            data_o <= mem[rd_idx];
          end
        end

        S_EOM: begin
          busy    <= 1'b0;
          valid_o <= 1'b0;
          data_o  <= '0;
          state   <= S_DONE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_encryption.sv
// tb/tb_zigzag_encryption.sv - directed self-checking bench for zigzag_encryption
module tb_zigzag_encryption;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key;
  logic       busy;
  logic [7:0] data_o;
  logic       valid_o;

  int checks = 0;
  int errors = 0;

`ifdef ZIGZAG_ENC_EOM_OUT_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  zigzag_encryption dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key     (key),
    .busy    (busy),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  function automatic string hexs(string s);
    string h = "";
    for (int n = 0; n < s.len(); n++) h = {h, $sformatf("%02h", s[n])};
    return h;
  endfunction

  function automatic string ex(string plain);
`ifdef ZIGZAG_ENC_EOM_OUT_EN
    return {hexs(plain), "fa"};
`else
    return hexs(plain);
`endif
  endfunction

  // Reference rail-fence by zigzag row assignment of each plaintext position.
  function automatic string railfence(string s, int kk);
    string o = "";
    int per;
    int m;
    int rw;
    if (kk <= 1) return s;
    per = 2 * (kk - 1);
    for (int row = 0; row < kk; row++) begin
      for (int j = 0; j < s.len(); j++) begin
        m  = j % per;
        rw = (m < kk) ? m : per - m;
        if (rw == row) o = {o, s.substr(j, j)};
      end
    end
    return o;
  endfunction

  task automatic check_str(string tag, string obs, string expv);
    checks++;
    assert (obs == expv) else begin
      errors++;
      $error("FAIL %s observed %s expected %s", tag, obs, expv);
    end
  endtask

  task automatic check_int(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic send(string s, int kv);
    for (int n = 0; n < s.len(); n++) begin
      valid_i = 1'b1;
      data_i  = s[n];
      @(posedge clk); #1;
    end
    valid_i = 1'b1;
    data_i  = 8'hFA;
    key     = 8'(kv);
    @(posedge clk); #1;
    valid_i = 1'b0;
    data_i  = 8'h00;
  endtask

  // Collects one burst; bad counts framing faults, a timeout adds 1000.
  task automatic capture(output string got, output int nv, output int nb, output int bad);
    int first;
    int last;
    bit done;
    got = ""; nv = 0; nb = 0; bad = 0; first = -1; last = -1; done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (!busy) begin
        if (valid_o || data_o != 8'h00) bad++;
        if (first >= 0 && (last - first + 1) != nv) bad++;
        if (first >= 0 && first != 1) bad++;
        done = 1;
      end else begin
        nb++;
        if (valid_o) begin
          got = {got, $sformatf("%02h", data_o)};
          nv++;
          if (first < 0) first = c;
          last = c;
        end else if (data_o != 8'h00) begin
          bad++;
        end
      end
    end
    if (!done) bad += 1000;
  endtask

  task automatic run_msg(string tag, string s, int kv, string cipher);
    string got;
    int nv, nb, bad;
    send(s, kv);
    capture(got, nv, nb, bad);
    check_str({tag, " data"}, got, ex(cipher));
    check_int({tag, " count"}, nv, cipher.len() + EXTRA);
    check_int({tag, " busy"}, nb, cipher.len() + 1 + EXTRA);
    check_int({tag, " frame"}, bad, 0);
  endtask

  initial begin
    string s60;
    string got;
    int nv, nb, bad, vcount;

    rst = 1'b1; valid_i = 1'b0; data_i = 8'h00; key = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("reset busy", int'(busy), 0);
    check_int("reset valid_o", int'(valid_o), 0);
    check_int("reset data_o", int'(data_o), 0);

    run_msg("k3 ABCDEFG", "ABCDEFG", 3, "AEBDFCG");
    run_msg("k2 ABCDEF", "ABCDEF", 2, "ACEBDF");
    run_msg("k1 XYZ", "XYZ", 1, "XYZ");
    run_msg("k0 XYZ", "XYZ", 0, "XYZ");
    run_msg("k200 XYZ", "XYZ", 200, "XYZ");
    run_msg("empty", "", 3, "");

    s60 = "";
    for (int n = 0; n < 60; n++) s60 = {s60, $sformatf("%c", 8'(8'h61 + n))};
    run_msg("sat k4", s60, 4, railfence(s60.substr(0, 49), 4));

    // Input toggling and a key change during EMIT must not disturb the burst.
    send("ABCDEFG", 3);
    fork
      capture(got, nv, nb, bad);
      begin
        for (int n = 0; n < 7; n++) begin
          valid_i = (n % 2) == 0;
          data_i  = (n == 6) ? 8'hFA : 8'h51;
          key     = 8'd2;
          @(posedge clk); #1;
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
      end
    join
    check_str("ignore data", got, ex("AEBDFCG"));
    check_int("ignore count", nv, 7 + EXTRA);
    check_int("ignore frame", bad, 0);
    run_msg("k3 HELLOWORLD", "HELLOWORLD", 3, "HOLELWRDLO");

    send("ABCDEFG", 3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("midreset busy", int'(busy), 0);
    check_int("midreset valid_o", int'(valid_o), 0);
    check_int("midreset data_o", int'(data_o), 0);
    vcount = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (valid_o || busy) vcount++;
    end
    check_int("midreset quiet", vcount, 0);
    run_msg("k2 ABC", "ABC", 2, "ACB");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zigzag_encryption.md
Name: zigzag_encryption

Overview:
- Rail-fence ("zigzag") encryption engine, the transmit-side counterpart of the zigzag decryption block.
- Buffers a byte-serial plaintext message terminated by 8'hFA.
- Then emits the ciphertext one byte per cycle: all rail-0 characters, then rail 1, and so on to rail key-1.
- Sits in the cipher datapath beside the decryption blocks and shares their data/valid/busy interface.

Parameters:
- DATA_WIDTH, 8, character width in bits.
- KEY_WIDTH, 8, key width in bits.
- MAX_LEN, 50, message buffer depth in characters, terminator excluded.
- EOM_CHAR, 8'hFA, end-of-message character.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- data_i  in  DATA_WIDTH  plaintext character.
- valid_i  in  1  data_i is valid this cycle.
- key  in  KEY_WIDTH  number of rails; sampled on the cycle the terminator is accepted.
- busy  out  1  engine is encrypting; input is ignored while high.
- data_o  out  DATA_WIDTH  ciphertext character.
- valid_o  out  1  data_o is valid this cycle.

Behaviour:
- Reset: busy=0, valid_o=0, data_o=0, length=0, state=IDLE. Reset applies in any state; an in-flight message is discarded and no further valid_o is produced.
- IDLE (collect):
  - valid_i=1 and data_i!=EOM_CHAR: store the character at buf[len], then len++.
  - If len==MAX_LEN, the character is dropped and len saturates.
  - valid_i=1 and data_i==EOM_CHAR: latch k=key and go to SETUP. The terminator is not stored.
- SETUP: lasts 1 cycle with busy=1. Sets the period p=2*(k-1), the rail r=0, the index i=0 and the step toggle.
  - If len==0, go straight to DONE.
- EMIT: busy=1, valid_o=1, data_o=buf[i], one character every cycle with no bubbles.
  - Index walk for k>=2:
    - Rails 0 and k-1 step by p.
    - Middle rail r alternates steps of p-2r and 2r, starting with p-2r.
  - When the next i would be >=len, move to rail r+1 with i=r+1.
  - If r+1>=k or r+1>=len, this character is the last one and the next state is DONE. Empty rails are therefore never visited.
  - k<=1: identity order, i=0..len-1.
  - k>=len: every rail holds at most one character, so the output equals the input order.
  - Index/period arithmetic is at least 10 bits wide, so no wraparound is possible for key up to 255.
- DONE: 1 cycle with busy=0 and valid_o=0. Clears len, then returns to IDLE.
  - A valid_i in the DONE cycle is accepted as the first character of the next message.
- Timing:
  - Terminator accepted at edge E0.
  - busy is high from E0 until the edge that ends the last valid_o cycle.
  - The first valid_o cycle follows E1.
  - Exactly len valid_o cycles occur, back-to-back.
- valid_i while busy=1 (SETUP/EMIT) is ignored, including EOM_CHAR.
- data_o=0 whenever valid_o=0.

Optional Feature:
- Macro ZIGZAG_ENC_EOM_OUT_EN.
- When defined: after the last ciphertext character, one extra valid_o cycle drives data_o=EOM_CHAR with busy still high. This also applies to an empty message, which then produces a single EOM_CHAR.
- When undefined: no terminator is emitted, and an empty message produces zero valid_o cycles.

Test Plan:
- Key 3, input "ABCDEFG" then 8'hFA -> busy high, valid_o on 7 consecutive cycles with data_o "AEBDFCG" (41 45 42 44 46 43 47), then busy low.
- Key 2, input "ABCDEF",FA -> "ACEBDF"; key 1 and key 0 with "XYZ",FA -> "XYZ"; key 200 with "XYZ",FA -> "XYZ".
- FA alone, key 3 -> busy pulses 1 cycle, no valid_o. With ZIGZAG_ENC_EOM_OUT_EN -> a single valid_o cycle with data_o=8'hFA.
- 60 characters 'a'..., then FA, key 4 -> exactly 50 outputs, matching rail-fence order of the first 50 characters; characters 51-60 are dropped.
- Valid_i toggling "QQQ" and FA during EMIT of a key-3 message -> output unaffected. The next message "HELLOWORLD",FA with key 3 -> "HOLELWRDLO".
- Assert rst for 1 cycle mid-EMIT -> next cycle busy=0, valid_o=0, data_o=0. A new message "ABC",FA key 2 -> "ACB".
